spec_path_matcher: RTL and testbench
====================================

# spec_path_matcher

Speculative-path matcher sitting directly upstream of the CFLog monitor in the SpecCFA attestation datapath. Watches each control-flow log word as it is written. Compares the stream against a small table of speculated subpaths programmed by the TCB. Drives `detect_active` / `active_block_cflog_addr` into the log monitor so a fully matched subpath is collapsed into a single path-ID entry at the subpath's start address.

## Interface
- `NUM_PATHS`, 4: number of speculated subpaths (1..8).
- `PATH_LEN`, 8: max log words per subpath (1..15).
- `SPEC_BASE`, 16'h0180: byte base address of the programming window.
- `clk` input 1: system clock.
- `puc_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `data_wr` input 1: CPU data write strobe.
- `data_addr` input 16: CPU data byte address.
- `data_wdata` input 16: CPU write data.
- `log_wen` input 1: one-cycle strobe; a log word is being written this cycle.
- `log_data` input 16: log word being written (branch source or destination).
- `log_ptr` input 16: log pointer of that word.
- `flush` input 1: log flush in progress; abandons any match.
- `detect_active` output 1: a partial match is being tracked.
- `active_block_cflog_addr` output 16: log pointer of the first word of the tracked subpath.
- `spec_hit` output 1: one-cycle pulse; a subpath completed.
- `spec_id` output 3: index of the completed subpath; valid with `spec_hit`.
- `hit_cnt` output NUM_PATHS*16: per-path hit counters, only with `SPEC_HIT_CNT_EN`.

## Operation
- Table: per path p, `len[p]` (4 bits, 0 = disabled) and `ent[p][0..PATH_LEN-1]` (16 bits each).
- Word address of slot k for path p is `SPEC_BASE + 2*(p*(PATH_LEN+1)+k)`.
  - k=0 is `len`; k=1..PATH_LEN is `ent[k-1]`.
  - A written `len` value greater than PATH_LEN is stored as PATH_LEN.
  - Writes are accepted only in IDLE; writes in any other state are dropped.
- FSM states: IDLE, TRACK, COMMIT.
- IDLE:
  - On `log_wen`, form `cand[p] = (len[p]!=0) && (log_data==ent[p][0])`.
  - If any candidate has `len==1`, go to COMMIT with the lowest such p.
  - Otherwise, if `cand` is nonzero, latch `start_ptr = log_ptr`, set `depth = 1`, and go to TRACK.
- TRACK, on `log_wen`:
  - `cand[p] &= (log_data==ent[p][depth])`, then `depth++`.
  - If any surviving p has `len[p]==depth+1`, go to COMMIT with the lowest such p.
  - If `cand` becomes 0, go to IDLE. The same word is re-evaluated as a fresh IDLE start in that cycle, so a mismatching word can itself begin a new match with a new `start_ptr`.
- COMMIT: pulse `spec_hit` with `spec_id`, clear `cand`, then go to IDLE. A `log_wen` arriving in COMMIT is evaluated as in IDLE.
- `flush` has priority over everything except reset: go to IDLE, clear `cand` and `depth`, no `spec_hit`.
- Priority on simultaneous completions: lowest path index.
- `depth` is 4 bits and never exceeds PATH_LEN. Paths shorter than `depth` are dropped from `cand`.

## Timing
- All outputs are registered.
- `detect_active` rises the cycle after the `log_wen` that enters TRACK. It falls the cycle after leaving TRACK.
- `active_block_cflog_addr` updates together with `detect_active` and holds until the next TRACK entry.
- `spec_hit` asserts the cycle after the completing `log_wen` and lasts exactly 1 cycle. `detect_active` is 0 in that cycle.
- Table writes take effect the cycle after `data_wr`.
- Reset (`puc_n` low, asynchronous):
  - State = IDLE; all `len`, `ent`, `cand` and `depth` = 0.
  - Outputs `detect_active`=0, `active_block_cflog_addr`=0, `spec_hit`=0, `spec_id`=0, `hit_cnt`=0.
  - Reset mid-TRACK discards the match with no `spec_hit`.

## Configuration
- `SPEC_HIT_CNT_EN` defined:
  - Adds a 16-bit counter per path, incremented on each `spec_hit` for that path and saturating at 16'hFFFF.
  - Counters clear on reset only; `flush` does not clear them.
  - Counters are exported on `hit_cnt`, with path p at bits `[16p+15:16p]`.
- Not defined: counters and the `hit_cnt` port are absent; matching behaviour is unchanged.

## Test plan
- Program path0 with `len=3` and entries E010, E020, E030. Drive `log_wen` with those words at ptrs 0x10..0x12 -> `detect_active`=1 with addr 0x0010 after the first word; `spec_hit`=1 with `spec_id`=0 one cycle after the third word.
- Same program, stream E010, E020, E044 -> `detect_active` drops after E044; no `spec_hit`.
- Program path1 with `len=2` {E010,E020} and path2 with `len=2` {E010,E020}. Stream E010, E020 -> `spec_id`=1 (lowest index wins).
- Program path0 with `len=1` {E100}. Send a single `log_wen` with E100 -> `spec_hit` next cycle; `detect_active` never asserts.
- Start TRACK, then assert `flush`; separately, pull `puc_n` low mid-TRACK -> state IDLE, no `spec_hit`. After reset, `len` reads as disabled and E010 causes no match.
- With `SPEC_HIT_CNT_EN`, preload path0's count to 0xFFFF via 65535 hits (or force), then hit once more -> `hit_cnt[15:0]` stays 0xFFFF.

Source files
------------

// File: rtl/spec_path_matcher.sv
// Purpose: tracks CFLog words against a TCB-programmed table of speculated subpaths; optional per-path hit counters (SPEC_HIT_CNT_EN).
// Latency: detect_active / active_block_cflog_addr / spec_hit are registered, one cycle after the qualifying log_wen.
// Backpressure: none; the log stream is never stalled, and table writes outside IDLE are dropped.
module spec_path_matcher #(
    parameter int          NUM_PATHS = 4,
    parameter int          PATH_LEN  = 8,
    parameter logic [15:0] SPEC_BASE = 16'h0180
) (
    input  logic        clk,
    input  logic        puc_n,
    input  logic        data_wr,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    input  logic        log_wen,
    input  logic [15:0] log_data,
    input  logic [15:0] log_ptr,
    input  logic        flush,
    output logic        detect_active,
    output logic [15:0] active_block_cflog_addr,
    output logic        spec_hit,
    output logic [2:0]  spec_id
`ifdef SPEC_HIT_CNT_EN
    ,
    output logic [NUM_PATHS*16-1:0] hit_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_COMMIT} state_t;

    state_t               r_state, w_state_nxt;
    logic [3:0]           r_len [NUM_PATHS];
    logic [15:0]          r_ent [NUM_PATHS][PATH_LEN];
    logic [NUM_PATHS-1:0] r_cand, w_cand_nxt;
    logic [3:0]           r_depth, w_depth_nxt;
    logic                 r_detect_active;
    logic [15:0]          r_start_ptr;
    logic                 r_spec_hit;
    logic [2:0]           r_spec_id;

    logic [15:0]          w_sel [NUM_PATHS];
    logic [NUM_PATHS-1:0] w_fresh_cand, w_fresh_done, w_trk_cand, w_trk_done;
    logic                 w_eval_fresh, w_load_start, w_hit;
    logic [2:0]           w_hit_id;

    // Word address of table slot k of path p (k=0 is the length word).
    function automatic logic [15:0] f_addr(input int p, input int k);
        return 16'(32'(SPEC_BASE) + 2 * (p * (PATH_LEN + 1) + k));
    endfunction

    // Lowest set index wins when several paths complete together.
    function automatic logic [2:0] f_lowest(input logic [NUM_PATHS-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = NUM_PATHS - 1; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    // TCB programming window; lengths above PATH_LEN are clamped.
    always_ff @(posedge clk or negedge puc_n) begin
        if (!puc_n) begin
            for (int p = 0; p < NUM_PATHS; p++) begin
                r_len[p] <= '0;
                for (int k = 0; k < PATH_LEN; k++) r_ent[p][k] <= '0;
            end
        end else if (data_wr && (r_state == S_IDLE)) begin
            for (int p = 0; p < NUM_PATHS; p++) begin
                if (data_addr == f_addr(p, 0))
                    r_len[p] <= (data_wdata > 16'(PATH_LEN)) ? 4'(PATH_LEN) : data_wdata[3:0];
                for (int k = 0; k < PATH_LEN; k++) begin
                    if (data_addr == f_addr(p, k + 1)) r_ent[p][k] <= data_wdata;
                end
            end
        end
    end

    // Per-path compare of the current log word, both as a fresh start and as a continuation.
    always_comb begin
        w_sel        = '{default: '0};
        w_fresh_cand = '0;
        w_fresh_done = '0;
        w_trk_cand   = '0;
        w_trk_done   = '0;
        for (int p = 0; p < NUM_PATHS; p++) begin
            for (int k = 0; k < PATH_LEN; k++) begin
                if (r_depth == 4'(k)) w_sel[p] = r_ent[p][k];
            end
            w_fresh_cand[p] = (r_len[p] != 4'd0) && (log_data == r_ent[p][0]);
            w_fresh_done[p] = w_fresh_cand[p] && (r_len[p] == 4'd1);
            w_trk_cand[p]   = r_cand[p] && (r_len[p] > r_depth) && (log_data == w_sel[p]);
            w_trk_done[p]   = w_trk_cand[p] && (r_len[p] == 4'(r_depth + 4'd1));
        end
    end

    // Next-state logic; a failed TRACK word or any word seen in COMMIT is re-evaluated as a fresh start.
    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_depth_nxt  = r_depth;
        w_eval_fresh = 1'b0;
        w_load_start = 1'b0;
        w_hit        = 1'b0;
        w_hit_id     = '0;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cand_nxt  = '0;
            w_depth_nxt = '0;
        end else begin
            case (r_state)
                S_TRACK: begin
                    if (log_wen) begin
                        if (|w_trk_done) begin
                            w_state_nxt = S_COMMIT;
                            w_hit       = 1'b1;
                            w_hit_id    = f_lowest(w_trk_done);
                            w_cand_nxt  = '0;
                            w_depth_nxt = '0;
                        end else if (|w_trk_cand) begin
                            w_cand_nxt  = w_trk_cand;
                            w_depth_nxt = r_depth + 4'd1;
                        end else begin
                            w_eval_fresh = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_cand_nxt   = '0;
                    w_depth_nxt  = '0;
                    w_eval_fresh = log_wen;
                end
            endcase
            if (w_eval_fresh) begin
                if (|w_fresh_done) begin
                    w_state_nxt = S_COMMIT;
                    w_hit       = 1'b1;
                    w_hit_id    = f_lowest(w_fresh_done);
                    w_cand_nxt  = '0;
                    w_depth_nxt = '0;
                end else if (|w_fresh_cand) begin
                    w_state_nxt  = S_TRACK;
                    w_cand_nxt   = w_fresh_cand;
                    w_depth_nxt  = 4'd1;
                    w_load_start = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cand_nxt  = '0;
                    w_depth_nxt = '0;
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge puc_n) begin
        if (!puc_n) begin
            r_state         <= S_IDLE;
            r_cand          <= '0;
            r_depth         <= '0;
            r_detect_active <= 1'b0;
            r_start_ptr     <= '0;
            r_spec_hit      <= 1'b0;
            r_spec_id       <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_cand          <= w_cand_nxt;
            r_depth         <= w_depth_nxt;
            r_detect_active <= (w_state_nxt == S_TRACK);
            r_spec_hit      <= w_hit;
            if (w_load_start) r_start_ptr <= log_ptr;
            if (w_hit)        r_spec_id   <= w_hit_id;
        end
    end

    assign detect_active           = r_detect_active;
    assign active_block_cflog_addr = r_start_ptr;
    assign spec_hit                = r_spec_hit;
    assign spec_id                 = r_spec_id;

`ifdef SPEC_HIT_CNT_EN
    logic [15:0] r_cnt [NUM_PATHS];

    // Saturating per-path hit counters; only reset clears them.
    always_ff @(posedge clk or negedge puc_n) begin
        if (!puc_n) begin
            for (int p = 0; p < NUM_PATHS; p++) r_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PATHS; p++) begin
                if (w_hit && (w_hit_id == 3'(p)) && (r_cnt[p] != 16'hFFFF))
                    r_cnt[p] <= r_cnt[p] + 16'd1;
            end
        end
    end

    // Pack counters, path p at bits [16p+15:16p].
    always_comb begin
        hit_cnt = '0;
        for (int p = 0; p < NUM_PATHS; p++) hit_cnt[16*p +: 16] = r_cnt[p];
    end
`endif

endmodule

// File: tb/tb_spec_path_matcher.sv
// Directed bench for spec_path_matcher: programs the path table and streams log words.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
// Hit counters are checked only when SPEC_HIT_CNT_EN is defined.
module tb_spec_path_matcher;

    logic        clk = 1'b0;
    logic        puc_n = 1'b0;
    logic        data_wr = 1'b0;
    logic [15:0] data_addr = '0;
    logic [15:0] data_wdata = '0;
    logic        log_wen = 1'b0;
    logic [15:0] log_data = '0;
    logic [15:0] log_ptr = '0;
    logic        flush = 1'b0;
    logic        detect_active;
    logic [15:0] active_block_cflog_addr;
    logic        spec_hit;
    logic [2:0]  spec_id;
`ifdef SPEC_HIT_CNT_EN
    logic [63:0] hit_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    spec_path_matcher dut (
        .clk                     (clk),
        .puc_n                   (puc_n),
        .data_wr                 (data_wr),
        .data_addr               (data_addr),
        .data_wdata              (data_wdata),
        .log_wen                 (log_wen),
        .log_data                (log_data),
        .log_ptr                 (log_ptr),
        .flush                   (flush),
        .detect_active           (detect_active),
        .active_block_cflog_addr (active_block_cflog_addr),
        .spec_hit                (spec_hit),
        .spec_id                 (spec_id)
`ifdef SPEC_HIT_CNT_EN
        ,
        .hit_cnt                 (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        data_wr = 1'b1; data_addr = a; data_wdata = d;
        @(negedge clk);
        data_wr = 1'b0;
    endtask

    task automatic lw(input logic [15:0] d, input logic [15:0] p);
        log_wen = 1'b1; log_data = d; log_ptr = p;
        @(negedge clk);
        log_wen = 1'b0; flush = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    initial begin
        // reset state
        idle(); idle();
        chk("rst_detect", 32'(detect_active), 0);
        chk("rst_addr",   32'(active_block_cflog_addr), 0);
        chk("rst_hit",    32'(spec_hit), 0);
        chk("rst_id",     32'(spec_id), 0);
        puc_n = 1'b1;
        idle();

        // path0 len3 {E010,E020,E030}: full match
        wr(16'h0180, 16'd3);
        wr(16'h0182, 16'hE010);
        wr(16'h0184, 16'hE020);
        wr(16'h0186, 16'hE030);
        lw(16'hE010, 16'h0010);
        chk("t1_detect_w1", 32'(detect_active), 1);
        chk("t1_addr_w1",   32'(active_block_cflog_addr), 32'h0010);
        chk("t1_hit_w1",    32'(spec_hit), 0);
        lw(16'hE020, 16'h0011);
        chk("t1_detect_w2", 32'(detect_active), 1);
        lw(16'hE030, 16'h0012);
        chk("t1_hit",        32'(spec_hit), 1);
        chk("t1_id",         32'(spec_id), 0);
        chk("t1_detect_hit", 32'(detect_active), 0);
        idle();
        chk("t1_hit_pulse", 32'(spec_hit), 0);

        // mismatch on third word
        lw(16'hE010, 16'h0020);
        lw(16'hE020, 16'h0021);
        chk("t2_detect_w2", 32'(detect_active), 1);
        lw(16'hE044, 16'h0022);
        chk("t2_detect_drop", 32'(detect_active), 0);
        chk("t2_no_hit",      32'(spec_hit), 0);

        // path1 and path2 both {E010,E020}: lowest index wins
        wr(16'h0192, 16'd2);
        wr(16'h0194, 16'hE010);
        wr(16'h0196, 16'hE020);
        wr(16'h01A4, 16'd2);
        wr(16'h01A6, 16'hE010);
        wr(16'h01A8, 16'hE020);
        lw(16'hE010, 16'h0030);
        lw(16'hE020, 16'h0031);
        chk("t3_hit", 32'(spec_hit), 1);
        chk("t3_id",  32'(spec_id), 1);
        idle();

        // path3 length 20 clamps to 8
        wr(16'h01B6, 16'd20);
        for (int k = 0; k < 8; k++) wr(16'(16'h01B8 + 2 * k), 16'(16'hE0A0 + k));
        for (int k = 0; k < 4; k++) lw(16'(16'hE0A0 + k), 16'(16'h0080 + k));
        chk("t4_clamp_no_hit4", 32'(spec_hit), 0);
        chk("t4_clamp_detect4", 32'(detect_active), 1);
        for (int k = 4; k < 8; k++) lw(16'(16'hE0A0 + k), 16'(16'h0080 + k));
        chk("t4_hit8", 32'(spec_hit), 1);
        chk("t4_id8",  32'(spec_id), 3);
        idle();

        // path0 len1 {E100}: immediate commit, no TRACK
        wr(16'h0180, 16'd1);
        wr(16'h0182, 16'hE100);
        lw(16'hE100, 16'h0040);
        chk("t5_hit",    32'(spec_hit), 1);
        chk("t5_id",     32'(spec_id), 0);
        chk("t5_detect", 32'(detect_active), 0);
        idle();

        // mismatching word restarts a match; write during TRACK is dropped
        lw(16'hE010, 16'h0050);
        lw(16'hE010, 16'h0051);
        chk("t6_restart_detect", 32'(detect_active), 1);
        chk("t6_restart_addr",   32'(active_block_cflog_addr), 32'h0051);
        wr(16'h0192, 16'd0);
        lw(16'hE020, 16'h0052);
        chk("t6_hit", 32'(spec_hit), 1);
        chk("t6_id",  32'(spec_id), 1);
        idle();

        // flush together with the completing word
        lw(16'hE010, 16'h0060);
        flush = 1'b1;
        lw(16'hE020, 16'h0061);
        chk("t7_flush_hit",    32'(spec_hit), 0);
        chk("t7_flush_detect", 32'(detect_active), 0);
        // flush alone mid-TRACK
        lw(16'hE010, 16'h0062);
        chk("t7_detect", 32'(detect_active), 1);
        flush = 1'b1;
        idle();
        flush = 1'b0;
        chk("t7_flush_drop", 32'(detect_active), 0);
        lw(16'hE020, 16'h0063);
        chk("t7_after_flush_hit", 32'(spec_hit), 0);

`ifdef SPEC_HIT_CNT_EN
        chk("cnt_p0", 32'(hit_cnt[15:0]),  2);
        chk("cnt_p1", 32'(hit_cnt[31:16]), 2);
        chk("cnt_p2", 32'(hit_cnt[47:32]), 0);
        chk("cnt_p3", 32'(hit_cnt[63:48]), 1);
`endif

        // reset mid-TRACK
        lw(16'hE010, 16'h0070);
        chk("t8_detect", 32'(detect_active), 1);
        puc_n = 1'b0;
        #1;
        chk("t8_rst_detect", 32'(detect_active), 0);
        chk("t8_rst_addr",   32'(active_block_cflog_addr), 0);
        chk("t8_rst_id",     32'(spec_id), 0);
`ifdef SPEC_HIT_CNT_EN
        chk("t8_rst_cnt", 32'(hit_cnt[31:0]), 0);
`endif
        idle();
        puc_n = 1'b1;
        idle();
        lw(16'hE010, 16'h0071);
        chk("t8_post_detect", 32'(detect_active), 0);
        chk("t8_post_hit",    32'(spec_hit), 0);
        lw(16'hE100, 16'h0072);
        chk("t8_post_len1_hit", 32'(spec_hit), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
